// File: rtl/time_pkg.sv
// Shared types and constants for the digital clock time-unit counters.
package time_pkg;

  // Counting direction as seen on the up_dn pin.
  typedef enum logic {
    DIR_DOWN = 1'b0,
    DIR_UP   = 1'b1
  } dir_e;

  // Standard moduli for the clock fields.
  localparam int SEC_MOD  = 60;
  localparam int MIN_MOD  = 60;
  localparam int HOUR_MOD = 24;

  // Packed two-digit BCD width used by the display path.
  localparam int BCD_W    = 8;

endpackage

// File: rtl/time_unit_counter_if.sv
// Control/status bundle of one time-unit counter stage.
interface time_unit_counter_if #(
  parameter int WIDTH = 6
);
  import time_pkg::*;

  logic                 tick_in;
  logic                 up_dn;
  logic                 hold;
  logic                 load_en;
  logic [WIDTH-1:0]     load_value;
  logic [WIDTH-1:0]     count;
  logic [BCD_W-1:0]     count_bcd;
  logic                 tc_out;
  logic                 carry_out;
  logic                 load_err;

  // Controller side: drives ticks, direction, hold and loads.
  modport master (
    output tick_in, up_dn, hold, load_en, load_value,
    input  count, count_bcd, tc_out, carry_out, load_err
  );

  // Counter side.
  modport slave (
    input  tick_in, up_dn, hold, load_en, load_value,
    output count, count_bcd, tc_out, carry_out, load_err
  );

endinterface

// File: rtl/time_bin2bcd.sv
// Binary 0..99 to packed two-digit BCD converter, purely combinational.
module time_bin2bcd
  import time_pkg::*;
#(
  parameter int WIDTH = 6
) (
  input  logic [WIDTH-1:0] bin,
  output logic [BCD_W-1:0] bcd
);

  logic [7:0] bin8_s;
  logic [3:0] tens_s;
  logic [3:0] units_s;

  // Split the value into decimal tens and units digits.
  always_comb begin
    bin8_s  = 8'(bin);
    tens_s  = 4'(bin8_s / 8'd10);
    units_s = 4'(bin8_s % 8'd10);
    bcd     = {tens_s, units_s};
  end

endmodule

// File: rtl/time_unit_counter.sv
// Parametrised modulo-N time-unit counter with up/down, hold, checked load,
// registered carry/borrow pulse, combinational terminal count and BCD view.
module time_unit_counter
  import time_pkg::*;
#(
  parameter int MODULUS     = SEC_MOD,
  parameter int WIDTH       = $clog2(MODULUS),
  parameter int RESET_VALUE = 0
) (
  input  logic                clk,
  input  logic                rst,
  time_unit_counter_if.slave  bus
);

  // Reject impossible configurations at elaboration time.
  if ((MODULUS < 2) || (MODULUS > 100)) begin : g_bad_modulus
    $error("time_unit_counter: MODULUS must be in 2..100");
  end
  if ((RESET_VALUE < 0) || (RESET_VALUE >= MODULUS)) begin : g_bad_reset_value
    $error("time_unit_counter: RESET_VALUE must be below MODULUS");
  end
  if (WIDTH < $clog2(MODULUS)) begin : g_bad_width
    $error("time_unit_counter: WIDTH too small for MODULUS");
  end

  localparam logic [WIDTH-1:0] ZERO_C    = {WIDTH{1'b0}};
  localparam logic [WIDTH-1:0] MAX_C     = WIDTH'(MODULUS - 1);
  localparam logic [WIDTH-1:0] RESET_C   = WIDTH'(RESET_VALUE);
  // One extra bit so MODULUS itself is representable (e.g. 64 in 6 bits).
  localparam logic [WIDTH:0]   MOD_EXT_C = (WIDTH + 1)'(MODULUS);

  logic [WIDTH-1:0] count_r;
  logic             carry_r;
  logic             load_err_r;

  dir_e             dir_s;
  logic             wrap_s;
  logic [WIDTH-1:0] step_s;
  logic             load_ok_s;
  logic             tc_s;

  // Next value for an accepted tick, wrap detection and load range check.
  always_comb begin
    dir_s     = dir_e'(bus.up_dn);
    wrap_s    = 1'b0;
    step_s    = count_r;
    load_ok_s = ({1'b0, bus.load_value} < MOD_EXT_C);
    case (dir_s)
      DIR_UP: begin
        wrap_s = (count_r == MAX_C);
        if (wrap_s) begin
          step_s = ZERO_C;
        end else begin
          step_s = count_r + {{(WIDTH-1){1'b0}}, 1'b1};
        end
      end
      DIR_DOWN: begin
        wrap_s = (count_r == ZERO_C);
        if (wrap_s) begin
          step_s = MAX_C;
        end else begin
          step_s = count_r - {{(WIDTH-1){1'b0}}, 1'b1};
        end
      end
      default: begin
        wrap_s = 1'b0;
        step_s = count_r;
      end
    endcase
    // Zero-lag cascade output: only a tick that will really be accepted counts.
    tc_s = bus.tick_in & ~bus.hold & ~bus.load_en & ~rst & wrap_s;
  end

  // Count state with priority rst > load > hold > tick > idle.
  always_ff @(posedge clk) begin
    if (rst) begin
      count_r    <= RESET_C;
      carry_r    <= 1'b0;
      load_err_r <= 1'b0;
    end else if (bus.load_en) begin
      carry_r <= 1'b0;
      if (load_ok_s) begin
        count_r    <= bus.load_value;
        load_err_r <= 1'b0;
      end else begin
        load_err_r <= 1'b1;
      end
    end else if (bus.hold) begin
      carry_r    <= 1'b0;
      load_err_r <= 1'b0;
    end else if (bus.tick_in) begin
      count_r    <= step_s;
      carry_r    <= wrap_s;
      load_err_r <= 1'b0;
    end else begin
      carry_r    <= 1'b0;
      load_err_r <= 1'b0;
    end
  end

  assign bus.count     = count_r;
  assign bus.carry_out = carry_r;
  assign bus.load_err  = load_err_r;
  assign bus.tc_out    = tc_s;

  time_bin2bcd #(
    .WIDTH (WIDTH)
  ) u_bin2bcd (
    .bin (count_r),
    .bcd (bus.count_bcd)
  );

endmodule

// File: tb/tb_time_unit_counter.sv
// Self-checking bench: seconds/minutes/hours cascade plus a 24-stage with
// non-zero reset value, checked against an arithmetic reference model.
module tb_time_unit_counter;

  logic clk;
  logic rst;

  int checks;
  int failures;

  time_unit_counter_if #(.WIDTH(6)) sec_if ();
  time_unit_counter_if #(.WIDTH(6)) min_if ();
  time_unit_counter_if #(.WIDTH(5)) hour_if ();
  time_unit_counter_if #(.WIDTH(5)) r24_if ();

  time_unit_counter #(.MODULUS(60), .WIDTH(6), .RESET_VALUE(0)) u_sec (
    .clk (clk), .rst (rst), .bus (sec_if.slave));
  time_unit_counter #(.MODULUS(60), .WIDTH(6), .RESET_VALUE(0)) u_min (
    .clk (clk), .rst (rst), .bus (min_if.slave));
  time_unit_counter #(.MODULUS(24), .WIDTH(5), .RESET_VALUE(0)) u_hour (
    .clk (clk), .rst (rst), .bus (hour_if.slave));
  time_unit_counter #(.MODULUS(24), .WIDTH(5), .RESET_VALUE(12)) u_r24 (
    .clk (clk), .rst (rst), .bus (r24_if.slave));

  // Zero-lag cascade: each stage ticks on the terminal count of the one below.
  assign min_if.tick_in  = sec_if.tc_out;
  assign hour_if.tick_in = min_if.tc_out;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Seconds-stage stimulus and model state.
  bit s_tick, s_up, s_hold, s_load;
  int s_lv;
  int exp_sec;
  bit e_tc, e_cy, e_er;
  logic tc_sec_o, tc_min_o, tc_hour_o, tc_r24_o;

  // Reference model: one clock of a modulo-m counter in plain arithmetic.
  function automatic void ref_step(input int m, input int rv, input int c,
                                   input bit r, input bit ld, input int lv,
                                   input bit hd, input bit tk, input bit up,
                                   output int nc, output bit cy,
                                   output bit er, output bit tc);
    nc = c; cy = 1'b0; er = 1'b0;
    tc = tk && !hd && !ld && !r && (up ? (c == m - 1) : (c == 0));
    if (r) nc = rv;
    else if (ld) begin
      if (lv < m) nc = lv;
      else er = 1'b1;
    end else if (!hd && tk) begin
      nc = up ? (c + 1) % m : (c + m - 1) % m;
      cy = up ? (c + 1 >= m) : (c == 0);
    end
  endfunction

  function automatic logic [7:0] bcd_of(input int v);
    return 8'(((v / 10) << 4) | (v % 10));
  endfunction

  // Sample combinational tc just after inputs settle, then cross one edge.
  task automatic step();
    #1;
    tc_sec_o  = sec_if.tc_out;
    tc_min_o  = min_if.tc_out;
    tc_hour_o = hour_if.tc_out;
    tc_r24_o  = r24_if.tc_out;
    @(posedge clk);
    #1;
  endtask

  // Apply seconds stimulus, advance the model and the DUT by one clock.
  task automatic sec_cycle();
    int nc;
    sec_if.tick_in    = s_tick;
    sec_if.up_dn      = s_up;
    sec_if.hold       = s_hold;
    sec_if.load_en    = s_load;
    sec_if.load_value = 6'(s_lv);
    ref_step(60, 0, exp_sec, rst, s_load, s_lv, s_hold, s_tick, s_up, nc, e_cy, e_er, e_tc);
    step();
    exp_sec = nc;
  endtask

  task automatic set_idle();
    rst = 1'b0;
    s_tick = 1'b0; s_up = 1'b1; s_hold = 1'b0; s_load = 1'b0; s_lv = 0;
    min_if.up_dn = 1'b1;  min_if.hold = 1'b0;  min_if.load_en = 1'b0;  min_if.load_value = 6'd0;
    hour_if.up_dn = 1'b1; hour_if.hold = 1'b0; hour_if.load_en = 1'b0; hour_if.load_value = 5'd0;
    r24_if.tick_in = 1'b0; r24_if.up_dn = 1'b1; r24_if.hold = 1'b0;
    r24_if.load_en = 1'b0; r24_if.load_value = 5'd0;
  endtask

  task automatic test_reset();
    set_idle();
    rst = 1'b1;
    sec_cycle();
    rst = 1'b0;
    checks++; if (sec_if.count !== 6'd0) begin failures++; $display("FAIL reset_count: got %0d expected 0", sec_if.count); end
    checks++; if (sec_if.carry_out !== 1'b0) begin failures++; $display("FAIL reset_carry: got %0b expected 0", sec_if.carry_out); end
    checks++; if (sec_if.load_err !== 1'b0) begin failures++; $display("FAIL reset_err: got %0b expected 0", sec_if.load_err); end
    checks++; if (sec_if.count_bcd !== 8'h00) begin failures++; $display("FAIL reset_bcd: got %h expected 00", sec_if.count_bcd); end
    checks++; if (r24_if.count !== 5'd12) begin failures++; $display("FAIL reset_r24: got %0d expected 12", r24_if.count); end
    checks++; if (r24_if.count_bcd !== 8'h12) begin failures++; $display("FAIL reset_r24_bcd: got %h expected 12", r24_if.count_bcd); end
  endtask

  task automatic test_count_up();
    int n_carry;
    n_carry = 0;
    set_idle();
    s_tick = 1'b1; s_up = 1'b1;
    for (int i = 0; i < 60; i++) begin
      sec_cycle();
      if (sec_if.carry_out === 1'b1) n_carry++;
      checks++; if (tc_sec_o !== e_tc) begin failures++; $display("FAIL up_tc[%0d]: got %0b expected %0b", i, tc_sec_o, e_tc); end
      checks++; if (sec_if.count !== 6'(exp_sec)) begin failures++; $display("FAIL up_count[%0d]: got %0d expected %0d", i, sec_if.count, exp_sec); end
      checks++; if (sec_if.carry_out !== e_cy) begin failures++; $display("FAIL up_carry[%0d]: got %0b expected %0b", i, sec_if.carry_out, e_cy); end
      checks++; if (sec_if.count_bcd !== bcd_of(exp_sec)) begin failures++; $display("FAIL up_bcd[%0d]: got %h expected %h", i, sec_if.count_bcd, bcd_of(exp_sec)); end
    end
    checks++; if (sec_if.count !== 6'd0) begin failures++; $display("FAIL up_final: got %0d expected 0", sec_if.count); end
    checks++; if (n_carry != 1) begin failures++; $display("FAIL up_carry_count: got %0d expected 1", n_carry); end
  endtask

  task automatic test_count_down();
    set_idle();
    s_load = 1'b1; s_lv = 0;
    sec_cycle();
    s_load = 1'b0; s_tick = 1'b1; s_up = 1'b0;
    sec_cycle();
    checks++; if (tc_sec_o !== 1'b1) begin failures++; $display("FAIL dn_tc: got %0b expected 1", tc_sec_o); end
    checks++; if (sec_if.count !== 6'd59) begin failures++; $display("FAIL dn_wrap: got %0d expected 59", sec_if.count); end
    checks++; if (sec_if.carry_out !== 1'b1) begin failures++; $display("FAIL dn_borrow: got %0b expected 1", sec_if.carry_out); end
    sec_cycle();
    checks++; if (sec_if.count !== 6'd58) begin failures++; $display("FAIL dn_next: got %0d expected 58", sec_if.count); end
    checks++; if (sec_if.carry_out !== 1'b0) begin failures++; $display("FAIL dn_no_borrow: got %0b expected 0", sec_if.carry_out); end
  endtask

  task automatic test_load();
    set_idle();
    s_load = 1'b1; s_lv = 60;
    sec_cycle();
    checks++; if (sec_if.load_err !== 1'b1) begin failures++; $display("FAIL ld_err: got %0b expected 1", sec_if.load_err); end
    checks++; if (sec_if.count !== 6'(exp_sec)) begin failures++; $display("FAIL ld_bad_count: got %0d expected %0d", sec_if.count, exp_sec); end
    s_load = 1'b0;
    sec_cycle();
    checks++; if (sec_if.load_err !== 1'b0) begin failures++; $display("FAIL ld_err_pulse: got %0b expected 0", sec_if.load_err); end
    s_load = 1'b1; s_lv = 59; s_tick = 1'b1; s_up = 1'b1;
    sec_cycle();
    checks++; if (tc_sec_o !== 1'b0) begin failures++; $display("FAIL ld_tc: got %0b expected 0", tc_sec_o); end
    checks++; if (sec_if.count !== 6'd59) begin failures++; $display("FAIL ld_count: got %0d expected 59", sec_if.count); end
    checks++; if (sec_if.carry_out !== 1'b0) begin failures++; $display("FAIL ld_carry: got %0b expected 0", sec_if.carry_out); end
    checks++; if (sec_if.load_err !== 1'b0) begin failures++; $display("FAIL ld_ok_err: got %0b expected 0", sec_if.load_err); end
    s_lv = 63;
    sec_cycle();
    checks++; if (sec_if.load_err !== 1'b1 || sec_if.count !== 6'd59) begin failures++; $display("FAIL ld_63: got err=%0b count=%0d expected err=1 count=59", sec_if.load_err, sec_if.count); end
  endtask

  task automatic test_hold();
    set_idle();
    s_load = 1'b1; s_lv = 30;
    sec_cycle();
    s_load = 1'b0; s_hold = 1'b1; s_tick = 1'b1; s_up = 1'b1;
    for (int i = 0; i < 5; i++) begin
      sec_cycle();
      checks++; if (sec_if.count !== 6'd30) begin failures++; $display("FAIL hold_count[%0d]: got %0d expected 30", i, sec_if.count); end
      checks++; if (tc_sec_o !== 1'b0 || sec_if.carry_out !== 1'b0) begin failures++; $display("FAIL hold_pulse[%0d]: got tc=%0b carry=%0b expected 0/0", i, tc_sec_o, sec_if.carry_out); end
    end
    s_hold = 1'b0;
    sec_cycle();
    checks++; if (sec_if.count !== 6'd31) begin failures++; $display("FAIL hold_release: got %0d expected 31", sec_if.count); end
  endtask

  task automatic test_random();
    set_idle();
    for (int i = 0; i < 400; i++) begin
      rst    = ($urandom_range(0, 49) == 0);
      s_load = ($urandom_range(0, 9) == 0);
      s_lv   = $urandom_range(0, 63);
      s_hold = ($urandom_range(0, 6) == 0);
      s_tick = ($urandom_range(0, 4) != 0);
      s_up   = $urandom_range(0, 1) == 1;
      sec_cycle();
      checks++; if (tc_sec_o !== e_tc) begin failures++; $display("FAIL rnd_tc[%0d]: got %0b expected %0b", i, tc_sec_o, e_tc); end
      checks++; if (sec_if.count !== 6'(exp_sec)) begin failures++; $display("FAIL rnd_count[%0d]: got %0d expected %0d", i, sec_if.count, exp_sec); end
      checks++; if (sec_if.carry_out !== e_cy) begin failures++; $display("FAIL rnd_carry[%0d]: got %0b expected %0b", i, sec_if.carry_out, e_cy); end
      checks++; if (sec_if.load_err !== e_er) begin failures++; $display("FAIL rnd_err[%0d]: got %0b expected %0b", i, sec_if.load_err, e_er); end
      checks++; if (sec_if.count_bcd !== bcd_of(exp_sec)) begin failures++; $display("FAIL rnd_bcd[%0d]: got %h expected %h", i, sec_if.count_bcd, bcd_of(exp_sec)); end
    end
    rst = 1'b0;
  endtask

  task automatic test_cascade();
    set_idle();
    s_load = 1'b1; s_lv = 59;
    min_if.load_en = 1'b1;  min_if.load_value = 6'd59;
    hour_if.load_en = 1'b1; hour_if.load_value = 5'd23;
    sec_cycle();
    s_load = 1'b0; min_if.load_en = 1'b0; hour_if.load_en = 1'b0;
    checks++; if ({sec_if.count_bcd, min_if.count_bcd, hour_if.count_bcd} !== 24'h595923) begin failures++; $display("FAIL casc_load: got %h expected 595923", {sec_if.count_bcd, min_if.count_bcd, hour_if.count_bcd}); end
    s_tick = 1'b1;
    sec_cycle();
    checks++; if ({tc_sec_o, tc_min_o, tc_hour_o} !== 3'b111) begin failures++; $display("FAIL casc_tc: got %b expected 111", {tc_sec_o, tc_min_o, tc_hour_o}); end
    checks++; if ({sec_if.count, min_if.count, hour_if.count} !== 17'd0) begin failures++; $display("FAIL casc_wrap: got %0d:%0d:%0d expected 0:0:0", hour_if.count, min_if.count, sec_if.count); end
    checks++; if ({sec_if.carry_out, min_if.carry_out, hour_if.carry_out} !== 3'b111) begin failures++; $display("FAIL casc_carry: got %b expected 111", {sec_if.carry_out, min_if.carry_out, hour_if.carry_out}); end
    s_tick = 1'b0;
    sec_cycle();
    checks++; if ({sec_if.carry_out, min_if.carry_out, hour_if.carry_out} !== 3'b000) begin failures++; $display("FAIL casc_carry_clear: got %b expected 000", {sec_if.carry_out, min_if.carry_out, hour_if.carry_out}); end
    s_tick = 1'b1; s_up = 1'b0; min_if.up_dn = 1'b0; hour_if.up_dn = 1'b0;
    sec_cycle();
    checks++; if ({sec_if.count_bcd, min_if.count_bcd, hour_if.count_bcd} !== 24'h595923) begin failures++; $display("FAIL casc_borrow: got %h expected 595923", {sec_if.count_bcd, min_if.count_bcd, hour_if.count_bcd}); end
    checks++; if ({sec_if.carry_out, min_if.carry_out, hour_if.carry_out} !== 3'b111) begin failures++; $display("FAIL casc_borrow_carry: got %b expected 111", {sec_if.carry_out, min_if.carry_out, hour_if.carry_out}); end
  endtask

  task automatic test_reset_wrap();
    set_idle();
    r24_if.load_en = 1'b1; r24_if.load_value = 5'd23;
    sec_cycle();
    r24_if.load_en = 1'b0; r24_if.tick_in = 1'b1;
    sec_cycle();
    checks++; if (r24_if.count !== 5'd0 || r24_if.carry_out !== 1'b1) begin failures++; $display("FAIL r24_wrap: got count=%0d carry=%0b expected 0/1", r24_if.count, r24_if.carry_out); end
    r24_if.tick_in = 1'b0; r24_if.load_en = 1'b1;
    sec_cycle();
    r24_if.load_en = 1'b0; r24_if.tick_in = 1'b1; rst = 1'b1;
    sec_cycle();
    rst = 1'b0; r24_if.tick_in = 1'b0;
    checks++; if (tc_r24_o !== 1'b0) begin failures++; $display("FAIL rstw_tc: got %0b expected 0", tc_r24_o); end
    checks++; if (r24_if.count !== 5'd12) begin failures++; $display("FAIL rstw_count: got %0d expected 12", r24_if.count); end
    checks++; if (r24_if.carry_out !== 1'b0) begin failures++; $display("FAIL rstw_carry: got %0b expected 0", r24_if.carry_out); end
    checks++; if (sec_if.count !== 6'(exp_sec)) begin failures++; $display("FAIL rstw_sec: got %0d expected %0d", sec_if.count, exp_sec); end
  endtask

  initial begin
    checks = 0;
    failures = 0;
    exp_sec = 0;
    set_idle();
    test_reset();
    test_count_up();
    test_count_down();
    test_load();
    test_hold();
    test_random();
    test_cascade();
    test_reset_wrap();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
